// File: rtl/cpu_types_pkg.sv
// Shared MIPS encodings plus the state and instruction-class types used by the
// multicycle control unit and its decoder.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20,
        FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
        FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL
    } aluop_t;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH, JUMP, HALTED
    } mc_state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_ALU_R, CLS_ALU_I, CLS_JR, CLS_LW, CLS_SW,
        CLS_BRANCH, CLS_J, CLS_JAL, CLS_LUI, CLS_HALT
    } instr_class_t;

    // Second ALU operand: sign/zero-extended immediate, register Rt, or shamt.
    localparam logic [1:0] SRC_IMM   = 2'b00;
    localparam logic [1:0] SRC_RT    = 2'b01;
    localparam logic [1:0] SRC_SHAMT = 2'b10;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] JSEL_SEQ  = 2'b00;
    localparam logic [1:0] JSEL_REG  = 2'b01;
    localparam logic [1:0] JSEL_JUMP = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the latched instruction and
// derives the ALU operation, operand select and extension mode.
module mc_decode
    import cpu_types_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output aluop_t       alu_op,
    output logic         ext_op,
    output logic [1:0]   alu_src,
    output logic         illegal
);

    always_comb begin
        // NOTE: every combinational output is given a default first so that no
        // path through the case statements can infer a latch.
        cls     = CLS_ILLEGAL;
        alu_op  = ALU_ADD;
        ext_op  = 1'b0;
        alu_src = SRC_RT;

        case (opcode)
            OP_RTYPE: begin
                cls = CLS_ALU_R;
                case (funct)
                    FN_SLL:          begin alu_op = ALU_SLL; alu_src = SRC_SHAMT; end
                    FN_SRL:          begin alu_op = ALU_SRL; alu_src = SRC_SHAMT; end
                    FN_JR:           cls = CLS_JR;
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    default:         cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin cls = CLS_ALU_I; alu_op = ALU_ADD;  ext_op = 1'b1; alu_src = SRC_IMM; end
            OP_SLTI:           begin cls = CLS_ALU_I; alu_op = ALU_SLT;  ext_op = 1'b1; alu_src = SRC_IMM; end
            OP_SLTIU:          begin cls = CLS_ALU_I; alu_op = ALU_SLTU; ext_op = 1'b1; alu_src = SRC_IMM; end
            OP_ANDI:           begin cls = CLS_ALU_I; alu_op = ALU_AND;  alu_src = SRC_IMM; end
            OP_ORI:            begin cls = CLS_ALU_I; alu_op = ALU_OR;   alu_src = SRC_IMM; end
            OP_XORI:           begin cls = CLS_ALU_I; alu_op = ALU_XOR;  alu_src = SRC_IMM; end
            OP_LW:             begin cls = CLS_LW;    ext_op = 1'b1; alu_src = SRC_IMM; end
            OP_SW:             begin cls = CLS_SW;    ext_op = 1'b1; alu_src = SRC_IMM; end
            OP_BEQ, OP_BNE:    begin cls = CLS_BRANCH; alu_op = ALU_SUB; end
            OP_J:              cls = CLS_J;
            OP_JAL:            cls = CLS_JAL;
            OP_LUI:            cls = CLS_LUI;
            OP_HALT:           cls = CLS_HALT;
            default:           cls = CLS_ILLEGAL;
        endcase

        illegal = (cls == CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences one instruction per pass through
// FETCH/DECODE/... on a shared memory port, with watchdog and retire counter.
module multicycle_control
    import cpu_types_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [DATA_W-1:0] imemload,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              zero,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              PCWrite,
    output logic              RegWr,
    output logic [1:0]        RegDst,
    output logic [1:0]        ALUsrc,
    output aluop_t            alu_op,
    output logic              ExtOp,
    output logic              MemToReg,
    output logic              LUI,
    output logic              JAL,
    output logic              PCsrc,
    output logic [1:0]        JumpSel,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [15:0]       imm16,
    output logic [DATA_W-1:0] shamt,
    output logic [CNT_W-1:0]  retired,
    output logic              halt,
    output logic              err
);

    // A zero-width watchdog is kept as a 1-bit counter whose expiry is masked.
    localparam int WD_W = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((1 << WD_W) - 2);

    mc_state_t         state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              err_q, err_d;

    instr_class_t cls;
    aluop_t       dec_alu_op;
    logic         dec_ext_op;
    logic [1:0]   dec_alu_src;
    logic         dec_illegal;
    logic         is_lw, is_beq, wd_expired, retire;

    mc_decode u_decode (
        .opcode  (ir_q[31:26]),
        .funct   (ir_q[5:0]),
        .cls     (cls),
        .alu_op  (dec_alu_op),
        .ext_op  (dec_ext_op),
        .alu_src (dec_alu_src),
        .illegal (dec_illegal)
    );

    assign is_lw      = (cls == CLS_LW);
    assign is_beq     = (ir_q[31:26] == OP_BEQ);
    assign wd_expired = (TIMEOUT_W != 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wd_d      = wd_q;
        retired_d = retired_q;
        err_d     = err_q;
        retire    = 1'b0;
        iREN      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        PCWrite   = 1'b0;
        RegWr     = 1'b0;
        RegDst    = REGDST_RT;
        ALUsrc    = SRC_IMM;
        alu_op    = ALU_ADD;
        ExtOp     = 1'b0;
        MemToReg  = 1'b0;
        LUI       = 1'b0;
        JAL       = 1'b0;
        PCsrc     = 1'b0;
        JumpSel   = JSEL_SEQ;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    ir_d    = imemload;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end else if (wd_expired) begin
                    state_d = HALTED;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DECODE: begin
                err_d = err_q | dec_illegal;
                case (cls)
                    CLS_ALU_R, CLS_ALU_I:     state_d = EXEC;
                    CLS_JR, CLS_J, CLS_JAL:   state_d = JUMP;
                    CLS_LW, CLS_SW:           state_d = ADDR;
                    CLS_BRANCH:               state_d = BRANCH;
                    CLS_LUI:                  state_d = WB;
                    default:                  state_d = HALTED;
                endcase
            end
            EXEC: begin
                ALUsrc  = dec_alu_src;
                alu_op  = dec_alu_op;
                ExtOp   = dec_ext_op;
                state_d = WB;
            end
            ADDR: begin
                ALUsrc  = SRC_IMM;
                ExtOp   = 1'b1;
                alu_op  = ALU_ADD;
                state_d = MEM;
            end
            MEM: begin
                dREN = is_lw;
                dWEN = !is_lw;
                if (dhit) begin
                    state_d = is_lw ? WB : FETCH;
                    retire  = !is_lw;
                end else if (wd_expired) begin
                    state_d = HALTED;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            WB: begin
                RegWr    = 1'b1;
                RegDst   = (cls == CLS_ALU_R) ? REGDST_RD : REGDST_RT;
                LUI      = (cls == CLS_LUI);
                MemToReg = is_lw;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUsrc  = SRC_RT;
                alu_op  = ALU_SUB;
                PCsrc   = is_beq ? zero : !zero;
                PCWrite = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                PCWrite = 1'b1;
                JumpSel = (cls == CLS_JR) ? JSEL_REG : JSEL_JUMP;
                if (cls == CLS_JAL) begin
                    RegWr  = 1'b1;
                    RegDst = REGDST_R31;
                    JAL    = 1'b1;
                end
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase

        // Each wait phase gets a fresh watchdog budget.
        if ((state_d != state_q) && (state_d == FETCH || state_d == MEM)) begin
            wd_d = '0;
        end
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments only; the IR is a
        // plain register and is cleared on reset like every other flop here.
        if (!nRST) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            wd_q      <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wd_q      <= wd_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign Rs      = ir_q[25:21];
    assign Rt      = ir_q[20:16];
    assign Rd      = ir_q[15:11];
    assign imm16   = ir_q[15:0];
    assign shamt   = {{(DATA_W-5){1'b0}}, ir_q[10:6]};
    assign retired = retired_q;
    assign halt    = (state_q == HALTED);
    assign err     = err_q;

endmodule
